// File: rtl/regwb_arbiter.sv
// Merges ALU/call results and buffered load returns onto the single register-file write port; build with REGWB_STALL_EN to enable the RAW stall comparators.
// Latency: ALU result written 1 cycle after acceptance; load written 2+ cycles after push (no bypass).
// Backpressure: ldReady/aluReady come from registered FIFO count and age only; a full or starved FIFO preempts the ALU.
module regwb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        aluValid,
    input  logic [3:0]  aluRd,
    input  logic [31:0] aluData,
    output logic        aluReady,
    input  logic        ldValid,
    input  logic [3:0]  ldRd,
    input  logic [31:0] ldData,
    output logic        ldReady,
    output logic        wbEn,
    output logic [3:0]  wbRd,
    output logic [31:0] wbData,
    input  logic [3:0]  rdA,
    input  logic [3:0]  rdB,
    output logic        stall
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] STARVE_C = AGE_W'(STARVE_LIMIT);

    logic [3:0]       rd_mem_q   [DEPTH];
    logic [3:0]       rd_mem_d   [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];
    logic [31:0]      data_mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             wb_en_q, wb_en_d;
    logic [3:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;

    logic empty, full, starved, load_wins, push;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign starved   = (age_q >= STARVE_C);
    assign load_wins = !empty && (full || starved || !aluValid);
    assign push      = ldValid && !full;

    assign ldReady  = !full;
    assign aluReady = !(!empty && (full || starved));
    assign wbEn     = wb_en_q;
    assign wbRd     = wb_rd_q;
    assign wbData   = wb_data_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_mem_d[i]   = rd_mem_q[i];
            data_mem_d[i] = data_mem_q[i];
        end
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        age_d     = age_q;
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;

        if (push) begin
            rd_mem_d[tail_q]   = ldRd;
            data_mem_d[tail_q] = ldData;
            tail_d             = tail_q + PTR_W'(1);
        end
        if (load_wins) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push && !load_wins) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && load_wins) begin
            count_d = count_q - CNT_W'(1);
        end

        // Age tracks how long the current head has been passed over.
        if (load_wins || empty) begin
            age_d = '0;
        end else if (!starved) begin
            age_d = age_q + AGE_W'(1);
        end

        if (load_wins) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = rd_mem_q[head_q];
            wb_data_d = data_mem_q[head_q];
        end else if (aluValid) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = aluRd;
            wb_data_d = aluData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            age_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= rd_mem_d[i];
                data_mem_q[i] <= data_mem_d[i];
            end
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            age_q     <= age_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

`ifdef REGWB_STALL_EN
    function automatic logic slot_live(input logic [PTR_W-1:0] idx,
                                       input logic [PTR_W-1:0] head,
                                       input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] off;
        off = idx - head;
        return ({1'b0, off} < cnt);
    endfunction

    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live(PTR_W'(i), head_q, count_q) &&
                (rd_mem_q[i] == rdA || rd_mem_q[i] == rdB)) begin
                stall = 1'b1;
            end
        end
        if (wb_en_q && (wb_rd_q == rdA || wb_rd_q == rdB)) begin
            stall = 1'b1;
        end
        if (ldValid && (ldRd == rdA || ldRd == rdB)) begin
            stall = 1'b1;
        end
    end
`else
    // Software schedules load-use distance; operand addresses are not compared.
    logic unused_operand_addrs;
    assign unused_operand_addrs = ^{rdA, rdB};
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed bench for regwb_arbiter: stimulus pushes hand-derived writes into a scoreboard, a negedge monitor checks every write.
module tb_regwb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        aluValid;
    logic [3:0]  aluRd;
    logic [31:0] aluData;
    logic        aluReady;
    logic        ldValid;
    logic [3:0]  ldRd;
    logic [31:0] ldData;
    logic        ldReady;
    logic        wbEn;
    logic [3:0]  wbRd;
    logic [31:0] wbData;
    logic [3:0]  rdA;
    logic [3:0]  rdB;
    logic        stall;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;

    regwb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .aluValid (aluValid),
        .aluRd    (aluRd),
        .aluData  (aluData),
        .aluReady (aluReady),
        .ldValid  (ldValid),
        .ldRd     (ldRd),
        .ldData   (ldData),
        .ldReady  (ldReady),
        .wbEn     (wbEn),
        .wbRd     (wbRd),
        .wbData   (wbData),
        .rdA      (rdA),
        .rdB      (rdB),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic exp_stall(input logic hazard);
`ifdef REGWB_STALL_EN
        return hazard;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [3:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [3:0] lrd, input logic [31:0] ldat);
        aluValid = av;
        aluRd    = ard;
        aluData  = adat;
        ldValid  = lv;
        ldRd     = lrd;
        ldData   = ldat;
    endtask

    task automatic expect_wb(input logic [3:0] rd, input logic [31:0] data, input int at);
        exp_q.push_back('{rd: rd, data: data, cyc: at});
    endtask

    // Monitor: every write must match the oldest expectation, in the expected cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            vectors++;
            fails++;
            $display("FAIL wb_missed: rd=%0d data=0x%0h due cycle %0d, still pending at cycle %0d",
                     exp_q[0].rd, exp_q[0].data, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (wbEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h at cycle %0d, want no write",
                         wbRd, wbData, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_rd", 32'(wbRd), 32'(e.rd));
                check("wb_data", wbData, e.data);
                check("wb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (wbEn !== 1'b0) begin
            check("wb_en_known", 32'(wbEn), 32'd0);
        end
    end

    initial begin
        rst_n = 1'b0;
        rdA   = 4'd0;
        rdB   = 4'd0;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        repeat (3) step();
        check("rst_wbEn", 32'(wbEn), 32'd0);
        check("rst_wbRd", 32'(wbRd), 32'd0);
        check("rst_wbData", wbData, 32'd0);
        check("rst_ldReady", 32'(ldReady), 32'd1);
        check("rst_aluReady", 32'(aluReady), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        step();
        step();

        // ALU write, one cycle latency, single-cycle wbEn
        drive(1'b1, 4'd3, 32'h1234, 1'b0, 4'd0, 32'd0);
        #1;
        check("t1_aluReady", 32'(aluReady), 32'd1);
        expect_wb(4'd3, 32'h1234, cyc + 1);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        step();
        step();

        // Load with ALU idle; stall tracked through ldValid, FIFO entry and wb stage
        rdA = 4'd5;
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hDEAD);
        #1;
        check("t2_ldReady", 32'(ldReady), 32'd1);
        check("t2_stall_ld", 32'(stall), 32'(exp_stall(1'b1)));
        expect_wb(4'd5, 32'hDEAD, cyc + 2);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        #1;
        check("t2_stall_fifo", 32'(stall), 32'(exp_stall(1'b1)));
        step();
        check("t2_stall_wb", 32'(stall), 32'(exp_stall(1'b1)));
        step();
        check("t2_stall_clear", 32'(stall), 32'd0);
        rdA = 4'd0;
        step();

        // Two loads fill the buffer while the ALU keeps requesting
        drive(1'b1, 4'd9, 32'h99, 1'b1, 4'd1, 32'h11);
        #1;
        check("t3_aluReady0", 32'(aluReady), 32'd1);
        expect_wb(4'd9, 32'h99, cyc + 1);
        step();
        drive(1'b1, 4'd10, 32'hAA, 1'b1, 4'd2, 32'h22);
        #1;
        check("t3_aluReady1", 32'(aluReady), 32'd1);
        check("t3_ldReady1", 32'(ldReady), 32'd1);
        expect_wb(4'd10, 32'hAA, cyc + 1);
        step();
        drive(1'b1, 4'd11, 32'hBB, 1'b0, 4'd0, 32'd0);
        #1;
        check("t3_aluReady_full", 32'(aluReady), 32'd0);
        check("t3_ldReady_full", 32'(ldReady), 32'd0);
        expect_wb(4'd1, 32'h11, cyc + 1);
        step();
        #1;
        check("t3_aluReady_after", 32'(aluReady), 32'd1);
        expect_wb(4'd11, 32'hBB, cyc + 1);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        expect_wb(4'd2, 32'h22, cyc + 1);
        step();
        step();

        // Starvation: one load against a continuously valid ALU
        for (int i = 0; i < 7; i++) begin
            logic [31:0] d;
            d = (i == 6) ? 32'hC05 : 32'hC00 + 32'(i);
            drive(1'b1, 4'd12, d, (i == 0), 4'd7, 32'h77);
            #1;
            check("t4_aluReady", 32'(aluReady), (i == 5) ? 32'd0 : 32'd1);
            if (i == 5) expect_wb(4'd7, 32'h77, cyc + 1);
            else        expect_wb(4'd12, d, cyc + 1);
            step();
        end
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        step();
        step();

        // Push and pop in the same cycle with one entry held
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'h44);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h66);
        #1;
        check("t5_ldReady_pp", 32'(ldReady), 32'd1);
        expect_wb(4'd4, 32'h44, cyc + 1);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        rdA = 4'd6;
        #1;
        check("t5_ldReady_after", 32'(ldReady), 32'd1);
        check("t5_stall_kept", 32'(stall), 32'(exp_stall(1'b1)));
        expect_wb(4'd6, 32'h66, cyc + 1);
        step();
        rdA = 4'd0;
        step();

        // Reset with two loads buffered: nothing buffered may be written afterwards
        drive(1'b1, 4'd13, 32'hD0, 1'b1, 4'd8, 32'h88);
        expect_wb(4'd13, 32'hD0, cyc + 1);
        step();
        drive(1'b1, 4'd13, 32'hD1, 1'b1, 4'd9, 32'h99);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        rdA = 4'd8;
        rdB = 4'd9;
        #1;
        check("t6_ldReady_full", 32'(ldReady), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_wbEn", 32'(wbEn), 32'd0);
        check("t6_rst_wbRd", 32'(wbRd), 32'd0);
        check("t6_rst_wbData", wbData, 32'd0);
        check("t6_rst_ldReady", 32'(ldReady), 32'd1);
        check("t6_rst_aluReady", 32'(aluReady), 32'd1);
        check("t6_rst_stall", 32'(stall), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        rdA = 4'd0;
        rdB = 4'd0;

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
